mem_line_buffer: RTL and testbench
==================================

Name: mem_line_buffer

Overview:
Single-line, write-through, write-allocate buffer placed directly downstream of the LC-3b CPU memory port.
- CPU side: the CPU's existing 16-bit word interface (mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, mem_rdata, mem_resp).
- Memory side: a 128-bit line-based physical memory port (pmem_*).
- Holds one 16-byte line, so sequential instruction fetches and nearby data accesses are served without a physical-memory round trip.

Parameters:
OFFSET_BITS, 4, log2 of line size in bytes; only 4 is supported (line = 8 words = 128 bits).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_byte_enable  input  2  lc3b_mem_wmask; [1]=high byte, [0]=low byte (writes only)
mem_address  input  16  CPU byte address, held until mem_resp
mem_wdata  input  16  CPU write data
mem_rdata  output  16  read data, valid while mem_resp=1
mem_resp  output  1  one-cycle completion pulse
pmem_read  output  1  line read request, held until pmem_resp
pmem_write  output  1  line write request, held until pmem_resp
pmem_address  output  16  line-aligned address {tag, 4'b0}
pmem_wdata  output  128  full line for write-through
pmem_rdata  input  128  line returned by physical memory
pmem_resp  input  1  physical memory completion pulse

Behaviour:
- Address split:
  - tag = mem_address[15:4]
  - word offset = mem_address[3:1]
  - mem_address[0] is ignored; byte selection uses mem_byte_enable only.
- State: valid (1b), tag_reg (12b), line_reg (128b), FSM.
- Word w of the line occupies line_reg[16w+15:16w].
- hit = valid && (tag_reg == mem_address[15:4]).
- Reset:
  - state=IDLE, valid=0.
  - tag_reg and line_reg become don't-care.
  - All outputs 0 (mem_resp, pmem_read, pmem_write, and address/data outputs driven 0).
- FSM states:
  - IDLE:
    - mem_write=1 (write takes priority if both are asserted):
      - hit: merge enabled bytes of mem_wdata into line_reg at offset; go to WRITE.
      - miss: go to FETCH.
    - else mem_read=1:
      - hit: go to RESP.
      - miss: go to FETCH.
    - else: stay in IDLE.
  - FETCH:
    - pmem_read=1, pmem_address={mem_address[15:4],4'b0}.
    - On pmem_resp: line_reg<=pmem_rdata, tag_reg<=tag, valid<=1, go to IDLE.
    - The request is then re-evaluated as a hit.
  - WRITE:
    - pmem_write=1, pmem_address={tag_reg,4'b0}, pmem_wdata=line_reg.
    - On pmem_resp: go to RESP.
  - RESP:
    - mem_resp=1 for exactly one cycle.
    - mem_rdata=line_reg word at offset (also driven on writes, value is don't-care to the CPU).
    - Go to IDLE.
- Latency (request sampled in IDLE to mem_resp):
  - read hit: 1 cycle.
  - read miss: fetch time + 2 cycles.
  - write hit: writeback time + 1 cycle.
  - write miss: fetch + writeback + 2 cycles.
- No combinational path from mem_* inputs to mem_resp.
- Byte merge:
  - be=01 writes the low byte only; be=10 the high byte only; be=11 the full word.
  - be=00 leaves the line unchanged but still performs the write-through and responds.
- pmem_read and pmem_write are never asserted together. Both are held steady (address/data stable) until pmem_resp.
- Request dropped mid-operation (CPU contract violation):
  - FETCH still completes and installs the line.
  - WRITE still completes.
  - No mem_resp is issued once the FSM reaches IDLE with no request; RESP still pulses if already entered.
- reset asserted in any state: next cycle IDLE with valid=0, and pmem_read/pmem_write deassert. A pmem_resp arriving after reset is ignored.
- A fetch that fails to complete leaves valid=0 (valid only set on pmem_resp in FETCH).
- The line is always consistent with memory (write-through), so no dirty bit and no eviction writeback; a miss simply overwrites.

Decomposition:
- lc3b_types additions: lc3b_line (128b), lc3b_line_tag (12b), lc3b_line_offset (3b), and an FSM state enum.
- Split matching the CPU's own structure:
  - mem_line_buffer_control: FSM, load strobes, pmem/mem handshakes.
  - mem_line_buffer_datapath: valid/tag/line registers, hit compare, word select, byte-merge logic.
  - mem_line_buffer: top module connecting the two.

Test Plan:
- Reset then read 0x1002 with memory line 0x1000 = words 0x1111..0x8888 (word0..7) -> pmem_read addr 0x1000, then mem_resp with rdata 0x2222; read 0x100E next -> resp 1 cycle later, rdata 0x8888, no pmem_read.
- Write hit 0x1004 be=01 wdata 0xABCD over 0x3333 -> pmem_write addr 0x1000 with word2=0x33CD, others unchanged; subsequent read 0x1004 returns 0x33CD from buffer.
- Write miss 0x2000 be=11 wdata 0xBEEF -> pmem_read 0x2000, then pmem_write 0x2000 word0=0xBEEF, then single mem_resp pulse.
- Read 0x1000 then 0x3000 then 0x1000 -> three fetches (tag replacement), correct data each time, pmem_write never asserted.
- Assert reset during FETCH with pmem_resp arriving the following cycle -> pmem_read low, pmem_resp ignored, next read of same address refetches.
- mem_read=mem_write=1 at 0x1006 be=10 wdata 0x5A00 on a hit -> treated as write: pmem_write, word3 high byte=0x5A, exactly one mem_resp.

Source files
------------

// File: rtl/mem_line_buffer_pkg.sv
// Shared types for the single-line write-through buffer between the LC-3b
// word port and the 128-bit physical memory port.
package mem_line_buffer_pkg;

    localparam int WORD_W = 16;
    localparam int LINE_W = 128;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [11:0]       lc3b_line_tag;
    typedef logic [2:0]        lc3b_line_offset;
    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [1:0]        lc3b_mem_wmask;

    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,
        LB_FETCH = 2'd1,
        LB_WRITE = 2'd2,
        LB_RESP  = 2'd3
    } lb_state_e;

    // be[1] selects the high byte, be[0] the low byte.
    function automatic lc3b_word merge_bytes(lc3b_word old_word, lc3b_word wdata,
                                             lc3b_mem_wmask be);
        lc3b_word result;
        result       = old_word;
        if (be[0]) result[7:0]  = wdata[7:0];
        if (be[1]) result[15:8] = wdata[15:8];
        return result;
    endfunction

endpackage

// File: rtl/mem_line_buffer_if.sv
// CPU word port and physical line port of the buffer, bundled together.
// Handshake: a request (mem_read/mem_write, pmem_read/pmem_write) is held with
// stable address/data until the matching one-cycle *_resp pulse completes it.
interface mem_line_buffer_if;
    import mem_line_buffer_pkg::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    logic [15:0]   mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    lc3b_line      pmem_wdata;
    lc3b_line      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_line_buffer_control.sv
// Buffer FSM: decides hit/miss handling and owns both request/response handshakes.
module mem_line_buffer_control
    import mem_line_buffer_pkg::*;
(
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      mem_read_i,
    input  logic      mem_write_i,
    input  logic      hit_i,
    input  logic      pmem_resp_i,
    output lb_state_e state_o,
    output logic      mem_resp_o,
    output logic      pmem_read_o,
    output logic      pmem_write_o,
    output logic      load_line_o,
    output logic      merge_o,
    output logic      addr_fetch_o,
    output logic      addr_write_o,
    output logic      rdata_en_o
);

    lb_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed fetch returns to IDLE so the held request re-resolves as a hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LB_IDLE: begin
                if (mem_write_i) begin
                    state_d = hit_i ? LB_WRITE : LB_FETCH;
                end else if (mem_read_i) begin
                    state_d = hit_i ? LB_RESP : LB_FETCH;
                end
            end
            LB_FETCH: if (pmem_resp_i) state_d = LB_IDLE;
            LB_WRITE: if (pmem_resp_i) state_d = LB_RESP;
            LB_RESP:  state_d = LB_IDLE;
            default:  state_d = LB_IDLE;
        endcase
    end

    always_comb begin
        mem_resp_o   = 1'b0;
        pmem_read_o  = 1'b0;
        pmem_write_o = 1'b0;
        load_line_o  = 1'b0;
        merge_o      = 1'b0;
        addr_fetch_o = 1'b0;
        addr_write_o = 1'b0;
        rdata_en_o   = 1'b0;
        case (state_q)
            LB_IDLE: merge_o = mem_write_i && hit_i;
            LB_FETCH: begin
                pmem_read_o  = 1'b1;
                addr_fetch_o = 1'b1;
                load_line_o  = pmem_resp_i;
            end
            LB_WRITE: begin
                pmem_write_o = 1'b1;
                addr_write_o = 1'b1;
            end
            LB_RESP: begin
                mem_resp_o = 1'b1;
                rdata_en_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/mem_line_buffer_datapath.sv
// Line storage: valid/tag/line registers, hit compare, word select and byte merge.
module mem_line_buffer_datapath
    import mem_line_buffer_pkg::*;
#(
    parameter int OFFSET_BITS = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [15:0]   mem_address_i,
    input  lc3b_word      mem_wdata_i,
    input  lc3b_mem_wmask mem_byte_enable_i,
    input  lc3b_line      pmem_rdata_i,
    input  logic          load_line_i,
    input  logic          merge_i,
    input  logic          addr_fetch_i,
    input  logic          addr_write_i,
    input  logic          rdata_en_i,
    output logic          hit_o,
    output lc3b_word      mem_rdata_o,
    output logic [15:0]   pmem_address_o,
    output lc3b_line      pmem_wdata_o
);

    logic            valid_q, valid_d;
    lc3b_line_tag    tag_q, tag_d;
    lc3b_line        line_q, line_d;
    lc3b_line_tag    req_tag;
    lc3b_line_offset req_offset;
    lc3b_word        sel_word;
    logic            unused_addr_lsb;

    assign req_tag         = mem_address_i[15:OFFSET_BITS];
    assign req_offset      = mem_address_i[OFFSET_BITS-1:1];
    assign unused_addr_lsb = mem_address_i[0];

    assign hit_o    = valid_q && (tag_q == req_tag);
    assign sel_word = line_q[{req_offset, 4'b0000} +: WORD_W];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        line_d  = line_q;
        if (load_line_i) begin
            valid_d = 1'b1;
            tag_d   = req_tag;
            line_d  = pmem_rdata_i;
        end else if (merge_i) begin
            line_d[{req_offset, 4'b0000} +: WORD_W] =
                merge_bytes(sel_word, mem_wdata_i, mem_byte_enable_i);
        end
    end

    // Tag and line are meaningless while valid is low, so only valid is reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    always_comb begin
        pmem_address_o = '0;
        if (addr_fetch_i) begin
            pmem_address_o = {req_tag, {OFFSET_BITS{1'b0}}};
        end else if (addr_write_i) begin
            pmem_address_o = {tag_q, {OFFSET_BITS{1'b0}}};
        end
    end

    assign pmem_wdata_o = addr_write_i ? line_q : '0;
    assign mem_rdata_o  = rdata_en_i ? sel_word : '0;

endmodule

// File: rtl/mem_line_buffer.sv
// Single-line write-through, write-allocate buffer between the LC-3b memory port
// and 128-bit physical memory. Only OFFSET_BITS = 4 (16-byte lines) is supported.
module mem_line_buffer
    import mem_line_buffer_pkg::*;
#(
    parameter int OFFSET_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_line_buffer_if.slave   bus,
    output lb_state_e          state_o
);

    logic hit;
    logic load_line;
    logic merge;
    logic addr_fetch;
    logic addr_write;
    logic rdata_en;

    mem_line_buffer_control u_control (
        .clk_i        (clk),
        .reset_i      (reset),
        .mem_read_i   (bus.mem_read),
        .mem_write_i  (bus.mem_write),
        .hit_i        (hit),
        .pmem_resp_i  (bus.pmem_resp),
        .state_o      (state_o),
        .mem_resp_o   (bus.mem_resp),
        .pmem_read_o  (bus.pmem_read),
        .pmem_write_o (bus.pmem_write),
        .load_line_o  (load_line),
        .merge_o      (merge),
        .addr_fetch_o (addr_fetch),
        .addr_write_o (addr_write),
        .rdata_en_o   (rdata_en)
    );

    mem_line_buffer_datapath #(
        .OFFSET_BITS (OFFSET_BITS)
    ) u_datapath (
        .clk_i             (clk),
        .reset_i           (reset),
        .mem_address_i     (bus.mem_address),
        .mem_wdata_i       (bus.mem_wdata),
        .mem_byte_enable_i (bus.mem_byte_enable),
        .pmem_rdata_i      (bus.pmem_rdata),
        .load_line_i       (load_line),
        .merge_i           (merge),
        .addr_fetch_i      (addr_fetch),
        .addr_write_i      (addr_write),
        .rdata_en_i        (rdata_en),
        .hit_o             (hit),
        .mem_rdata_o       (bus.mem_rdata),
        .pmem_address_o    (bus.pmem_address),
        .pmem_wdata_o      (bus.pmem_wdata)
    );

endmodule

// File: tb/tb_mem_line_buffer.sv
// Directed bench for mem_line_buffer: CPU driver task, a physical memory
// responder with fixed 2-cycle latency, and per-scenario checking tasks.
module tb_mem_line_buffer;
    import mem_line_buffer_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    lb_state_e state;

    always #5 clk = ~clk;

    mem_line_buffer_if bus ();

    mem_line_buffer #(
        .OFFSET_BITS (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state)
    );

    int checks = 0;
    int errors = 0;

    lc3b_line    pmem [logic [11:0]];
    bit          auto_mem   = 1'b0;
    logic        force_resp = 1'b0;
    lc3b_line    force_data = '0;
    int          n_rd = 0, n_wr = 0, n_both = 0, n_unstable = 0;
    int          cnt = 0;
    logic [15:0] last_rd_addr = '0, last_wr_addr = '0, held_addr = '0;
    lc3b_line    last_wr_data = '0, held_wdata = '0;

    // Physical memory model: answers each held request on its second cycle.
    always @(negedge clk) begin
        if (!auto_mem) begin
            bus.pmem_resp  = force_resp;
            bus.pmem_rdata = force_data;
            cnt = 0;
        end else begin
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) n_both++;
            if (bus.pmem_read || bus.pmem_write) begin
                if (cnt == 0) begin
                    held_addr  = bus.pmem_address;
                    held_wdata = bus.pmem_wdata;
                end else if (bus.pmem_address !== held_addr ||
                             (bus.pmem_write && bus.pmem_wdata !== held_wdata)) begin
                    n_unstable++;
                end
                cnt++;
                if (cnt == 2) begin
                    cnt = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) begin
                        bus.pmem_rdata = pmem.exists(bus.pmem_address[15:4]) ?
                                         pmem[bus.pmem_address[15:4]] : '0;
                        last_rd_addr = bus.pmem_address;
                        n_rd++;
                    end else begin
                        pmem[bus.pmem_address[15:4]] = bus.pmem_wdata;
                        last_wr_addr = bus.pmem_address;
                        last_wr_data = bus.pmem_wdata;
                        n_wr++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic cpu_op(input string name, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output int lat);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_address     = addr;
        bus.mem_wdata       = wdata;
        lat   = 0;
        rdata = 'x;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.mem_resp && lat < 100);
        checks++;
        if (bus.mem_resp !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: mem_resp=%b after %0d cycles, required 1", name, bus.mem_resp, lat);
        end
        rdata         = bus.mem_rdata;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: mem_resp=%b one cycle later, required 0", name, bus.mem_resp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_address = '0;
        bus.mem_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== LB_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", state, LB_IDLE);
        end
        checks++;
        if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000", {bus.mem_resp, bus.pmem_read, bus.pmem_write});
        end
        checks++;
        if (bus.pmem_address !== 16'h0 || bus.mem_rdata !== 16'h0 || bus.pmem_wdata !== 128'h0) begin
            errors++; $display("FAIL reset_data: got addr %h rdata %h wdata %h required 0", bus.pmem_address, bus.mem_rdata, bus.pmem_wdata);
        end
        reset = 1'b0;
        auto_mem = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_rd(input string name, input logic [15:0] addr,
                            input logic [15:0] exp_data, input int exp_lat);
        logic [15:0] rdata;
        int          lat;
        cpu_op(name, 1'b1, 1'b0, 2'b00, addr, 16'h0, rdata, lat);
        checks++;
        if (rdata !== exp_data) begin
            errors++; $display("FAIL %s_data: got %h required %h", name, rdata, exp_data);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
    endtask

    task automatic check_wr(input string name, input logic both, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input int exp_lat, input lc3b_line exp_line);
        logic [15:0] rdata;
        int          lat;
        int          wr0;
        wr0 = n_wr;
        cpu_op(name, both, 1'b1, be, addr, wdata, rdata, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (n_wr != wr0 + 1) begin
            errors++; $display("FAIL %s_wrcount: got %0d line writes required 1", name, n_wr - wr0);
        end
        checks++;
        if (last_wr_addr !== {addr[15:4], 4'h0}) begin
            errors++; $display("FAIL %s_wraddr: got %h required %h", name, last_wr_addr, {addr[15:4], 4'h0});
        end
        checks++;
        if (last_wr_data !== exp_line) begin
            errors++; $display("FAIL %s_wrdata: got %h required %h", name, last_wr_data, exp_line);
        end
    endtask

    task automatic test_read_miss_hit();
        int rd0;
        rd0 = n_rd;
        check_rd("rd_miss_1002", 16'h1002, 16'h2222, 4);
        checks++;
        if (last_rd_addr !== 16'h1000) begin
            errors++; $display("FAIL rd_miss_addr: got %h required 1000", last_rd_addr);
        end
        check_rd("rd_hit_100e", 16'h100E, 16'h8888, 1);
        checks++;
        if (n_rd != rd0 + 1) begin
            errors++; $display("FAIL rd_hit_fetches: got %0d required 1", n_rd - rd0);
        end
    endtask

    task automatic test_write_hit();
        int rd0;
        rd0 = n_rd;
        check_wr("wr_hit_1004", 1'b0, 2'b01, 16'h1004, 16'hABCD, 3,
                 128'h8888_7777_6666_5555_4444_33CD_2222_1111);
        check_rd("rd_after_wr_1004", 16'h1004, 16'h33CD, 1);
        checks++;
        if (n_rd != rd0) begin
            errors++; $display("FAIL wr_hit_fetches: got %0d required 0", n_rd - rd0);
        end
    endtask

    task automatic test_write_miss();
        int rd0;
        rd0 = n_rd;
        check_wr("wr_miss_2000", 1'b0, 2'b11, 16'h2000, 16'hBEEF, 6,
                 128'h2107_2106_2105_2104_2103_2102_2101_BEEF);
        checks++;
        if (n_rd != rd0 + 1 || last_rd_addr !== 16'h2000) begin
            errors++; $display("FAIL wr_miss_fetch: got %0d fetches at %h required 1 at 2000", n_rd - rd0, last_rd_addr);
        end
    endtask

    task automatic test_replacement();
        int rd0, wr0;
        rd0 = n_rd;
        wr0 = n_wr;
        check_rd("repl_1000_a", 16'h1000, 16'h1111, 4);
        check_rd("repl_3000", 16'h3000, 16'h3100, 4);
        check_rd("repl_1000_b", 16'h1000, 16'h1111, 4);
        check_rd("repl_1004_hit", 16'h1004, 16'h33CD, 1);
        checks++;
        if (n_rd != rd0 + 3 || n_wr != wr0) begin
            errors++; $display("FAIL repl_counts: got %0d fetches %0d writes required 3 and 0", n_rd - rd0, n_wr - wr0);
        end
    endtask

    task automatic test_byte_enable_zero();
        check_wr("wr_be00_100a", 1'b0, 2'b00, 16'h100A, 16'hFFFF, 3,
                 128'h8888_7777_6666_5555_4444_33CD_2222_1111);
        check_rd("rd_after_be00", 16'h100A, 16'h6666, 1);
    endtask

    task automatic test_reset_during_fetch();
        int wait_cnt;
        int rd0;
        auto_mem   = 1'b0;
        force_resp = 1'b0;
        force_data = {8{16'hDEAD}};
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h3002;
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!bus.pmem_read && wait_cnt < 20);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000) begin
            errors++; $display("FAIL rst_fetch_start: got pmem_read %b addr %h required 1 3000", bus.pmem_read, bus.pmem_address);
        end
        reset = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1;
        force_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b0 || state !== LB_IDLE) begin
            errors++; $display("FAIL rst_fetch_abort: got pmem_read %b state %0d required 0 0", bus.pmem_read, state);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        force_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== LB_IDLE || bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++; $display("FAIL rst_late_resp: got state %0d mem_resp %b pmem_read %b required 0 0 0", state, bus.mem_resp, bus.pmem_read);
        end
        auto_mem = 1'b1;
        @(negedge clk);
        rd0 = n_rd;
        check_rd("rst_1000_refetch", 16'h1000, 16'h1111, 4);
        check_rd("rst_3002_refetch", 16'h3002, 16'h3101, 4);
        checks++;
        if (n_rd != rd0 + 2) begin
            errors++; $display("FAIL rst_fetch_count: got %0d required 2", n_rd - rd0);
        end
    endtask

    task automatic test_read_write_both();
        int rd0;
        check_rd("both_pre_1006", 16'h1006, 16'h4444, 4);
        rd0 = n_rd;
        check_wr("both_1006", 1'b1, 2'b10, 16'h1006, 16'h5A00, 3,
                 128'h8888_7777_6666_5555_5A44_33CD_2222_1111);
        check_rd("both_post_1006", 16'h1006, 16'h5A44, 1);
        checks++;
        if (n_rd != rd0) begin
            errors++; $display("FAIL both_fetches: got %0d required 0", n_rd - rd0);
        end
    endtask

    initial begin
        pmem[12'h100] = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        pmem[12'h200] = 128'h2107_2106_2105_2104_2103_2102_2101_2100;
        pmem[12'h300] = 128'h3107_3106_3105_3104_3103_3102_3101_3100;

        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_write_miss();
        test_replacement();
        test_byte_enable_zero();
        test_reset_during_fetch();
        test_read_write_both();

        checks++;
        if (n_both != 0) begin
            errors++; $display("FAIL pmem_exclusive: got %0d overlap cycles required 0", n_both);
        end
        checks++;
        if (n_unstable != 0) begin
            errors++; $display("FAIL pmem_stable: got %0d unstable cycles required 0", n_unstable);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
